// File: rtl/multibyte_add_seq.sv
// Multi-precision add/subtract sequencer: streams one byte per cycle, LSB first,
// through an external combinational 8-bit adder, chaining the carry in a register.
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic                overflow,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_s,
  input  logic                add_cout
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_result;
  logic             r_carry_out;
  logic             r_overflow;

  logic             w_last;
  logic [W-1:0]     w_merged;
  logic             w_ovf;

  assign w_last = (r_idx == LAST_IDX);
  assign w_ovf  = (r_a[W-1] == r_b[W-1]) && (add_s[7] != r_a[W-1]);

  // The final byte goes straight into the result so no partial value is ever visible.
  always_comb begin
    w_merged          = r_acc;
    w_merged[W-1 -: 8] = add_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    add_a       = '0;
    add_b       = '0;
    add_cin     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        add_a   = r_a[{r_idx, 3'b000} +: 8];
        add_b   = r_b[{r_idx, 3'b000} +: 8];
        add_cin = r_carry;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= sub ? ~op_b : op_b;
            r_carry <= sub;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          // Every accumulator byte is overwritten each request, so it needs no clearing on start.
          r_acc[{r_idx, 3'b000} +: 8] <= add_s;
          r_carry                     <= add_cout;
          if (w_last) begin
            r_idx       <= '0;
            r_result    <= w_merged;
            r_carry_out <= add_cout;
            r_overflow  <= w_ovf;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule
